// File: rtl/game_sequencer_pkg.sv
// Shared types and widths for the dance-game sequencer.
// Optional pause support is compiled in with GAME_SEQ_PAUSE_EN.
package game_seq_pkg;

  localparam int ACC_W  = 40;
  localparam int BPM_W  = 16;
  localparam int SONG_W = 4;

  typedef enum logic [2:0] {
    ST_SELECT    = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DONE      = 3'd3,
    ST_PAUSE     = 3'd4
  } state_t;

  // Limits the BPM so the accumulator can wrap at most once per cycle.
  function automatic logic [BPM_W-1:0] clamp_bpm(input logic [BPM_W-1:0] bpm,
                                                 input logic [ACC_W-1:0] limit);
    if (ACC_W'(bpm) > limit) return limit[BPM_W-1:0];
    return bpm;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Button, selector and beat signals between the sequencer and the rest of the game.
interface game_sequencer_if;
  import game_seq_pkg::*;

  logic              btn_start;
  logic              btn_back;
  logic [SONG_W-1:0] selected_song;
  logic [BPM_W-1:0]  bpm_in;
  logic              sel_enable;
  logic [SONG_W-1:0] active_song;
  logic [BPM_W-1:0]  bpm_latched;
  logic [2:0]        state;
  logic              beat_tick;
  logic [7:0]        beat_count;
  logic              playing;
  logic              song_done;

  modport master (
    input  btn_start, btn_back, selected_song, bpm_in,
    output sel_enable, active_song, bpm_latched, state,
    output beat_tick, beat_count, playing, song_done
  );

  modport slave (
    output btn_start, btn_back, selected_song, bpm_in,
    input  sel_enable, active_song, bpm_latched, state,
    input  beat_tick, beat_count, playing, song_done
  );

endinterface

// File: rtl/game_sequencer_beat_timer.sv
// Phase accumulator turning a BPM into beat ticks; wrap is the look-ahead of
// the next registered tick so the sequencer can count beats on the same edge.
module beat_timer
  import game_seq_pkg::*;
#(
  parameter logic [ACC_W-1:0] LIMIT = 40'd3_000_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [BPM_W-1:0] bpm,
  output logic             wrap,
  output logic             tick
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] sum;

  assign sum  = acc_reg + ACC_W'(bpm);
  assign wrap = (sum >= LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      tick    <= 1'b0;
    end else if (clear) begin
      acc_reg <= '0;
      tick    <= 1'b0;
    end else if (run) begin
      // Remainder is carried over, so the long-run rate is exact.
      acc_reg <= wrap ? (sum - LIMIT) : sum;
      tick    <= wrap;
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: select -> countdown -> play -> done, with beat counting.
// Defining GAME_SEQ_PAUSE_EN lets a start press in PLAY pause/resume the song.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned COUNTDOWN_BEATS = 4,
  parameter int unsigned SONG_BEATS      = 64
) (
  input  logic              clk,
  input  logic              rst,
  game_sequencer_if.master  bus
);

  localparam logic [ACC_W-1:0] LIMIT   = ACC_W'(CLK_HZ) * ACC_W'(60);
  localparam logic [7:0]       CD_LAST = 8'(COUNTDOWN_BEATS);
  localparam logic [7:0]       SG_LAST = 8'(SONG_BEATS);

  state_t            state_reg, state_next;
  logic [7:0]        count_reg, count_next, count_inc;
  logic              start_q_reg, back_q_reg;
  logic              start_rise, back_rise;
  logic [SONG_W-1:0] song_reg;
  logic [BPM_W-1:0]  bpm_reg;
  logic              done_reg, done_next;
  logic              playing_reg, sel_en_reg;
  logic              latch, clear, run, pause_req, wrap, tick, beat_due;

  assign start_rise = bus.btn_start & ~start_q_reg;
  assign back_rise  = bus.btn_back & ~back_q_reg;
  assign count_inc  = count_reg + 8'd1;

`ifdef GAME_SEQ_PAUSE_EN
  assign pause_req = (state_reg == ST_PLAY) && start_rise && !back_rise;
`else
  assign pause_req = 1'b0;
`endif

  // The accumulator must not advance on an abort or pause edge.
  assign run      = ((state_reg == ST_COUNTDOWN) || (state_reg == ST_PLAY))
                    && !back_rise && !pause_req;
  assign beat_due = run && wrap;

  beat_timer #(.LIMIT(LIMIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (clear),
    .bpm   (bpm_reg),
    .wrap  (wrap),
    .tick  (tick)
  );

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    latch      = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      ST_SELECT: begin
        if (!back_rise && start_rise && (bus.bpm_in != '0)) begin
          latch      = 1'b1;
          clear      = 1'b1;
          count_next = '0;
          state_next = ST_COUNTDOWN;
        end
      end
      ST_COUNTDOWN: begin
        if (back_rise) begin
          clear      = 1'b1;
          count_next = '0;
          state_next = ST_SELECT;
        end else if (beat_due) begin
          if (count_inc == CD_LAST) begin
            count_next = '0;
            state_next = ST_PLAY;
          end else begin
            count_next = count_inc;
          end
        end
      end
      ST_PLAY: begin
        if (back_rise) begin
          clear      = 1'b1;
          count_next = '0;
          state_next = ST_SELECT;
        end else if (pause_req) begin
          state_next = ST_PAUSE;
        end else if (beat_due) begin
          count_next = count_inc;
          if (count_inc == SG_LAST) begin
            done_next  = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (back_rise) begin
          clear      = 1'b1;
          count_next = '0;
          state_next = ST_SELECT;
        end else if (start_rise) begin
          state_next = ST_PLAY;
        end
      end
      ST_DONE: begin
        if (start_rise || back_rise) begin
          count_next = '0;
          state_next = ST_SELECT;
        end
      end
      default: begin
        count_next = '0;
        state_next = ST_SELECT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_SELECT;
      count_reg   <= '0;
      start_q_reg <= 1'b0;
      back_q_reg  <= 1'b0;
      song_reg    <= '0;
      bpm_reg     <= '0;
      done_reg    <= 1'b0;
      playing_reg <= 1'b0;
      sel_en_reg  <= 1'b1;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      start_q_reg <= bus.btn_start;
      back_q_reg  <= bus.btn_back;
      done_reg    <= done_next;
      playing_reg <= (state_next == ST_PLAY);
      sel_en_reg  <= (state_next == ST_SELECT);
      if (latch) begin
        song_reg <= bus.selected_song;
        bpm_reg  <= clamp_bpm(bus.bpm_in, LIMIT);
      end
    end
  end

  assign bus.state       = state_reg;
  assign bus.beat_count  = count_reg;
  assign bus.beat_tick   = tick;
  assign bus.song_done   = done_reg;
  assign bus.playing     = playing_reg;
  assign bus.sel_enable  = sel_en_reg;
  assign bus.active_song = song_reg;
  assign bus.bpm_latched = bpm_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized scoreboard bench: a tick-count reference model predicts each cycle's outputs.
module tb_game_sequencer;

  localparam int L  = 120;
  localparam int CB = 2;
  localparam int SB = 4;
`ifdef GAME_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  typedef struct {
    int st; int sel; int tick; int cnt; int cnt_ok;
    int ply; int done; int song; int bpm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_sequencer_if bus();

  game_sequencer #(.CLK_HZ(2), .COUNTDOWN_BEATS(CB), .SONG_BEATS(SB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: beats so far = floor(active_cycles * bpm / LIMIT).
  int m_mode;   // 0 select, 1 running, 2 paused, 3 done
  int m_n, m_b, m_song, m_ps, m_pb;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int ticks(int n);
    return int'((longint'(n) * longint'(m_b)) / L);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_b = 0; m_song = 0; m_ps = 0; m_pb = 0;
  endtask

  task automatic model_step(output exp_t e);
    int sr, br, t;
    sr = (bus.btn_start && !m_ps) ? 1 : 0;
    br = (bus.btn_back && !m_pb) ? 1 : 0;
    m_ps = int'(bus.btn_start);
    m_pb = int'(bus.btn_back);
    e.tick = 0;
    e.done = 0;
    case (m_mode)
      0: if (!br && sr && bus.bpm_in != 0) begin
           m_song = int'(bus.selected_song);
           m_b    = (int'(bus.bpm_in) > L) ? L : int'(bus.bpm_in);
           m_n    = 0;
           m_mode = 1;
         end
      1: if (br) m_mode = 0;
         else if (PAUSE_EN && sr && ticks(m_n) >= CB) m_mode = 2;
         else begin
           m_n++;
           if (ticks(m_n) > ticks(m_n - 1)) e.tick = 1;
           if (ticks(m_n) >= CB + SB) begin
             m_mode = 3;
             e.done = 1;
           end
         end
      2: if (br) m_mode = 0;
         else if (sr) m_mode = 1;
      default: if (sr || br) m_mode = 0;
    endcase
    t = ticks(m_n);
    e.sel = (m_mode == 0) ? 1 : 0;
    e.cnt_ok = (m_mode == 0) ? 0 : 1;
    e.ply = (m_mode == 1 && t >= CB) ? 1 : 0;
    e.song = m_song;
    e.bpm = m_b;
    case (m_mode)
      0:       begin e.st = 0; e.cnt = 0; end
      1:       begin e.st = (t < CB) ? 1 : 2; e.cnt = (t < CB) ? t : t - CB; end
      2:       begin e.st = 4; e.cnt = t - CB; end
      default: begin e.st = 3; e.cnt = SB; end
    endcase
  endtask

  // Monitor: compares one predicted record just after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", int'(bus.state), e.st);
        chk("sel_enable", int'(bus.sel_enable), e.sel);
        chk("beat_tick", int'(bus.beat_tick), e.tick);
        if (e.cnt_ok != 0) chk("beat_count", int'(bus.beat_count), e.cnt);
        chk("playing", int'(bus.playing), e.ply);
        chk("song_done", int'(bus.song_done), e.done);
        chk("active_song", int'(bus.active_song), e.song);
        chk("bpm_latched", int'(bus.bpm_latched), e.bpm);
      end
    end
  end

  initial begin
    exp_t e;
    int bpm_tab[10] = '{0, 60, 80, 500, 120, 30, 7, 200, 1000, 65535};
    bit did_rst = 1'b0;

    rst = 1'b1;
    bus.btn_start = 1'b1;
    bus.btn_back = 1'b0;
    bus.bpm_in = 16'd60;
    bus.selected_song = 4'd3;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_sel_enable", int'(bus.sel_enable), 1);
    chk("rst_beat_tick", int'(bus.beat_tick), 0);
    chk("rst_beat_count", int'(bus.beat_count), 0);
    chk("rst_playing", int'(bus.playing), 0);
    chk("rst_song_done", int'(bus.song_done), 0);
    chk("rst_active_song", int'(bus.active_song), 0);
    chk("rst_bpm_latched", int'(bus.bpm_latched), 0);
    #2 rst = 1'b0;

    // First 16 edges: start held through reset at 60 BPM gives one full song.
    for (int i = 0; i < 4000; i++) begin
      if (!did_rst && i >= 2000 && m_mode == 1) begin
        did_rst = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_rst_state", int'(bus.state), 0);
        chk("async_rst_song_done", int'(bus.song_done), 0);
        chk("async_rst_beat_tick", int'(bus.beat_tick), 0);
        chk("async_rst_sel_enable", int'(bus.sel_enable), 1);
        #1 rst = 1'b0;
        model_reset();
      end
      if (i >= 16) begin
        bus.btn_start = ($urandom_range(0, 5) == 0);
        bus.btn_back  = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 9) == 0) begin
          bus.bpm_in = 16'(bpm_tab[$urandom_range(0, 9)]);
          bus.selected_song = 4'($urandom_range(0, 15));
        end
      end
      model_step(e);
      q.push_back(e);
      @(posedge clk);
      #2;
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for the dance game. Owns the song selector's `enable`, and runs the sequence select → countdown → play → done. Latches the chosen song and its BPM at start, then generates beat ticks from the BPM with a phase accumulator. Downstream arrow and scoring logic consume `beat_tick` and `beat_count`.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency. Defines `LIMIT = CLK_HZ*60`.
- `COUNTDOWN_BEATS`, default 4: beats before play. Must be 1..15.
- `SONG_BEATS`, default 64: song length in beats. Must be 1..255.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn_start` in 1: start/confirm button level. Already synchronised and debounced upstream.
- `btn_back` in 1: abort/back button level. Same conditioning as `btn_start`.
- `selected_song` in 4: song ID from the selector.
- `bpm_in` in 16: BPM from the selector.
- `sel_enable` out 1: enable to the song selector.
- `active_song` out 4: song ID latched at start.
- `bpm_latched` out 16: BPM latched at start, after clamping.
- `state` out 3: current state, encoded SELECT=0, COUNTDOWN=1, PLAY=2, DONE=3, PAUSE=4.
- `beat_tick` out 1: one-cycle pulse per beat.
- `beat_count` out 8: number of ticks in the current phase.
- `playing` out 1: high in PLAY.
- `song_done` out 1: one-cycle pulse on PLAY→DONE.

## Operation
- Button events are rising edges only: `rise = btn & ~btn_q`. Each `btn_q` resets to 0, so a button held through reset fires one rise on the first edge after reset.
- If `btn_back` and `btn_start` rise in the same cycle, back wins.
- SELECT:
  - `sel_enable=1`.
  - Start rise with `bpm_in != 0`: latch `active_song` and `bpm_latched = min(bpm_in, LIMIT)`, set acc=0 and `beat_count=0`, go to COUNTDOWN.
  - Start rise with `bpm_in == 0`: ignored.
- COUNTDOWN:
  - Accumulator runs.
  - Each tick increments `beat_count`.
  - The tick that makes `beat_count == COUNTDOWN_BEATS` instead moves to PLAY with `beat_count=0`.
- PLAY:
  - Accumulator runs; each tick increments `beat_count`.
  - The tick that makes `beat_count == SONG_BEATS` moves to DONE, pulses `song_done`, and holds `beat_count = SONG_BEATS`.
- DONE: start or back rise → SELECT.
- Back rise in COUNTDOWN, PLAY or PAUSE → SELECT on that edge. Acc is cleared and `beat_tick` is not asserted on that edge.
- Accumulator, active only in COUNTDOWN and PLAY:
  - `sum = acc + bpm_latched`, computed at 40-bit width.
  - If `sum >= LIMIT`: `acc <= sum - LIMIT` and `beat_tick <= 1`.
  - Otherwise: `acc <= sum` and `beat_tick <= 0`.
  - At most one tick per cycle; clamping guarantees this.
- `sel_enable` is 0 in every state except SELECT.
- `active_song` and `bpm_latched` hold until the next start.

## Timing
- Start rise sampled at edge N: `state = COUNTDOWN` after edge N.
- First tick is registered at edge `N + ceil(LIMIT/bpm)`. Later ticks average `LIMIT/bpm` cycles apart, with exact long-run rate and no drift.
- `beat_tick`, `beat_count`, the state change and `song_done` all update on the same edge.
- Reset values: `state` = SELECT, `sel_enable` = 1, `beat_tick` = 0, `beat_count` = 0, `playing` = 0, `song_done` = 0, `active_song` = 0, `bpm_latched` = 0, acc = 0.
- Reset mid-song returns to SELECT immediately and asynchronously; no `song_done` pulse.
- All outputs are registered.

## Configuration
- `GAME_SEQ_PAUSE_EN` defined:
  - Start rise in PLAY → PAUSE.
  - PAUSE: acc and `beat_count` frozen, `beat_tick=0`, `playing=0`.
  - Start rise in PAUSE → PLAY, resuming the accumulator from its frozen value.
- Not defined:
  - Start rise in PLAY is ignored.
  - PAUSE is unreachable; encoding 4 is never output.

## Structure
- `game_seq_pkg` holds:
  - the state enum and its encodings;
  - `ACC_W = 40`;
  - the `BPM_W = 16` and `SONG_W = 4` widths.
- Sub-module `beat_timer`:
  - contains the phase accumulator;
  - inputs: `run`, `clear`, `bpm`;
  - output: registered `tick`;
  - parameter: `LIMIT`.
- The sequencer FSM, edge detectors and latches stay in `game_sequencer`.

## Test plan
All scenarios use `CLK_HZ=2` (`LIMIT=120`), `COUNTDOWN_BEATS=2`, `SONG_BEATS=4`.
- Reset check: after reset, `state=0` and `sel_enable=1`. Hold `btn_start` high through reset with `bpm_in=60` → COUNTDOWN one edge after release of `rst`.
- Full run: `bpm_in=60`, `selected_song=3`, start rise → ticks every 2 cycles. PLAY after the 2nd tick, `song_done` on the 4th PLAY tick, `beat_count=4`, `active_song=3`, `sel_enable` low throughout.
- Fractional rate: `bpm_in=80` → tick spacing follows the pattern 2,1,… cycles, totalling 3 ticks per 4.5 cycles on average, i.e. exactly 4 ticks in 6 cycles.
- Clamp and guard: `bpm_in=0` start → stays SELECT. `bpm_in=500` → `bpm_latched=120`, tick every cycle.
- Abort: back rise during PLAY `beat_count=2` → SELECT next edge, `beat_tick=0`, `sel_enable=1`, no `song_done`. Start and back rising together in SELECT → stays SELECT.
- Pause (with `GAME_SEQ_PAUSE_EN`): start rise in PLAY at `beat_count=1` → `state=4`, no ticks for 10 cycles. Start rise again → PLAY, ticks resume with acc preserved.
